// File: rtl/aether_mem_pkg.sv
// Shared types and widths for the aether single-word memory command interface.
package aether_mem_pkg;

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LAT_W  = 4;

   typedef enum logic [1:0] {
      CMD_IDLE  = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2
   } mem_cmd_e;

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      REFRESH
   } resp_state_e;

   typedef struct packed {
      logic              is_read;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Only Write and Read start an operation; Idle and code 3 are ignored.
   function automatic logic is_valid_cmd(input logic [1:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_READ);
   endfunction

endpackage

// File: rtl/aether_mem_responder_if.sv
// Command/response bundle between a memory engine (master) and a responder (slave).
interface aether_mem_responder_if;
   import aether_mem_pkg::*;

   logic [1:0]        command_i;
   logic [ADDR_W-1:0] data_address_i;
   logic [DATA_W-1:0] data_write_i;
   logic [DATA_W-1:0] data_read_o;
   logic              data_read_valid_o;
   logic              data_write_done_o;
   logic              busy_o;

   modport master (
      output command_i, data_address_i, data_write_i,
      input  data_read_o, data_read_valid_o, data_write_done_o, busy_o
   );

   modport slave (
      input  command_i, data_address_i, data_write_i,
      output data_read_o, data_read_valid_o, data_write_done_o, busy_o
   );

endinterface

// File: rtl/single_port_bram.sv
// Single-port 16-bit RAM: synchronous write, registered read output cleared by reset.
module single_port_bram
   import aether_mem_pkg::*;
#(
   parameter int unsigned AddrWidth = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DATA_W-1:0]    wdata_i,
   output logic [DATA_W-1:0]    rdata_o
);

   localparam int unsigned DEPTH = 1 << AddrWidth;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Array contents deliberately have no reset.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/aether_mem_responder.sv
// BRAM-backed fixed-latency responder for the aether memory command interface.
// Optional refresh-stall emulation: define AETHER_MEM_RESPONDER_REFRESH_EN.
module aether_mem_responder
   import aether_mem_pkg::*;
#(
   parameter int unsigned AddrWidth     = 12,
   parameter int unsigned ReadLatency   = 3,
   parameter int unsigned WriteLatency  = 2,
   parameter int unsigned RefreshPeriod = 1024,
   parameter int unsigned RefreshCycles = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   aether_mem_responder_if.slave mem_if
);

   // Pulse register is set ReadLatency-1 edges after accept so it is seen in cycle N+Latency.
   localparam int unsigned RD_LOAD = ReadLatency - 2;
   localparam int unsigned WR_LOAD = (WriteLatency > 1) ? WriteLatency - 2 : 0;
   localparam bit          WR_NOW  = (WriteLatency == 1);

   resp_state_e       state_q;
   logic [LAT_W-1:0]  lat_q;
   mem_req_t          req_q;
   logic              rvalid_q;
   logic              wdone_q;
   logic              busy_q;
   logic [DATA_W-1:0] rdata;
   logic              we_c;
   logic              re_c;
   logic              live_valid_c;
   mem_req_t          live_req_c;
   logic              acc_c;
   mem_req_t          acc_req_c;
   logic              unused_c;

   assign live_valid_c = is_valid_cmd(mem_if.command_i);
   assign live_req_c   = '{is_read: (mem_if.command_i == CMD_READ),
                           addr:    mem_if.data_address_i,
                           wdata:   mem_if.data_write_i};

`ifdef AETHER_MEM_RESPONDER_REFRESH_EN
   localparam int unsigned REF_W   = $clog2(RefreshPeriod);
   localparam int unsigned STALL_W = $clog2(RefreshCycles + 1);

   logic [REF_W-1:0]   ref_cnt_q;
   logic               ref_req_q;
   logic [STALL_W-1:0] stall_q;
   mem_req_t           pend_q;
   logic               pend_v_q;
   logic               ref_take_c;

   assign ref_take_c = (state_q == IDLE) && ref_req_q;

   // Free-running request generator; a request waits here until the FSM is idle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ref_cnt_q <= '0;
         ref_req_q <= 1'b0;
      end else if (ref_cnt_q == REF_W'(RefreshPeriod - 1)) begin
         ref_cnt_q <= '0;
         ref_req_q <= 1'b1;
      end else begin
         ref_cnt_q <= ref_cnt_q + REF_W'(1);
         if (ref_take_c) ref_req_q <= 1'b0;
      end
   end

   // Exiting refresh replays a parked command, else takes one presented on the exit edge.
   assign acc_req_c = (state_q == REFRESH && pend_v_q) ? pend_q : live_req_c;
   assign acc_c     = (state_q == IDLE && !ref_req_q && live_valid_c) ||
                      (state_q == REFRESH && stall_q == '0 && (pend_v_q || live_valid_c));
`else
   assign acc_req_c = live_req_c;
   assign acc_c     = (state_q == IDLE) && live_valid_c;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         req_q    <= '0;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef AETHER_MEM_RESPONDER_REFRESH_EN
         stall_q  <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
`endif
      end else begin
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         case (state_q)
            IDLE: begin
`ifdef AETHER_MEM_RESPONDER_REFRESH_EN
               if (ref_req_q) begin
                  state_q <= REFRESH;
                  stall_q <= STALL_W'(RefreshCycles - 1);
                  busy_q  <= 1'b1;
               end
`endif
            end
            READ_WAIT: begin
               if (rvalid_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (lat_q == '0) begin
                  rvalid_q <= 1'b1;
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end
            WRITE_WAIT: begin
               if (wdone_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (lat_q == '0) begin
                  wdone_q <= 1'b1;
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end
            REFRESH: begin
`ifdef AETHER_MEM_RESPONDER_REFRESH_EN
               if (stall_q == '0) begin
                  pend_v_q <= 1'b0;
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
               end else begin
                  stall_q <= stall_q - STALL_W'(1);
                  if (!pend_v_q && live_valid_c) begin
                     pend_q   <= live_req_c;
                     pend_v_q <= 1'b1;
                  end
               end
`else
               state_q <= IDLE;
`endif
            end
         endcase
         if (acc_c) begin
            req_q   <= acc_req_c;
            busy_q  <= 1'b1;
            state_q <= acc_req_c.is_read ? READ_WAIT : WRITE_WAIT;
            lat_q   <= acc_req_c.is_read ? LAT_W'(RD_LOAD) : LAT_W'(WR_LOAD);
            wdone_q <= !acc_req_c.is_read && WR_NOW;
         end
      end
   end

   // Read is issued one edge before the pulse; write commits on the edge ending the pulse.
   assign re_c = (state_q == READ_WAIT) && !rvalid_q && (lat_q == '0);
   assign we_c = (state_q == WRITE_WAIT) && wdone_q && !rst_i;

   single_port_bram #(
      .AddrWidth (AddrWidth)
   ) u_bram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (we_c),
      .re_i    (re_c),
      .addr_i  (req_q.addr[AddrWidth-1:0]),
      .wdata_i (req_q.wdata),
      .rdata_o (rdata)
   );

   assign mem_if.data_read_o       = rdata;
   assign mem_if.data_read_valid_o = rvalid_q;
   assign mem_if.data_write_done_o = wdone_q;
   assign mem_if.busy_o            = busy_q;

   // High address bits alias away by design.
   assign unused_c = ^{req_q.is_read, req_q.addr[ADDR_W-1:AddrWidth]};

endmodule
